// File: rtl/permute_job_driver.sv
// permute_job_driver
//
// Sequences one permutation job at a time into a downstream pipeline:
// it latches the job's top function and lets it settle for TOP_SETTLE
// cycles, then streams the job's bots out one per transfer. After the
// last bot it pulses batchDone, waits for the pipeline's result,
// acknowledges it with grabResults and presents the result downstream
// until it is accepted.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   jobValid/jobReady         job handshake; jobTop, jobBotCount job payload
//   botIn/botInValid/botInReady  bot source handshake
//   top, bot, botValid        registered top/bot to the pipeline
//   batchDone                 one-cycle end-of-batch pulse
//   slowDownInput             pipeline backpressure, stalls bot transfers
//   resultsAvailable, pcoeffSum, pcoeffCount, eccStatus  pipeline result
//   grabResults               one-cycle result acknowledge to the pipeline
//   resultValid/resultReady   downstream result handshake
//   resultSum/resultCount/resultEcc  captured result
//   jobsCompleted             results delivered downstream (wraps)
module permute_job_driver #(
    parameter int TOP_SETTLE = 4,
    parameter int SUM_W      = 52,
    parameter int COUNT_W    = 17
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               jobValid,
    output logic               jobReady,
    input  logic [127:0]       jobTop,
    input  logic [15:0]        jobBotCount,
    input  logic [127:0]       botIn,
    input  logic               botInValid,
    output logic               botInReady,
    output logic [127:0]       top,
    output logic [127:0]       bot,
    output logic               botValid,
    output logic               batchDone,
    input  logic               slowDownInput,
    input  logic               resultsAvailable,
    input  logic [SUM_W-1:0]   pcoeffSum,
    input  logic [COUNT_W-1:0] pcoeffCount,
    input  logic               eccStatus,
    output logic               grabResults,
    output logic               resultValid,
    input  logic               resultReady,
    output logic [SUM_W-1:0]   resultSum,
    output logic [COUNT_W-1:0] resultCount,
    output logic               resultEcc,
    output logic [31:0]        jobsCompleted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_STREAM,
        S_DONE,
        S_WAIT_RES,
        S_GRAB,
        S_OUTPUT
    } state_t;

    // The settle counter runs 0..TOP_SETTLE-1; SETTLE always lasts at
    // least one cycle even if TOP_SETTLE is configured as 0.
    localparam int SETTLE_W = (TOP_SETTLE > 1) ? $clog2(TOP_SETTLE) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST =
        SETTLE_W'((TOP_SETTLE > 0) ? (TOP_SETTLE - 1) : 0);

    state_t               state_q, state_d;
    logic [SETTLE_W-1:0]  settle_cnt_q, settle_cnt_d;
    logic [15:0]          remaining_q, remaining_d;
    logic [127:0]         top_q, top_d;
    logic [127:0]         bot_q, bot_d;
    logic                 bot_valid_q, bot_valid_d;
    logic                 batch_done_q, batch_done_d;
    logic                 grab_results_q, grab_results_d;
    logic                 result_valid_q, result_valid_d;
    logic [SUM_W-1:0]     result_sum_q, result_sum_d;
    logic [COUNT_W-1:0]   result_count_q, result_count_d;
    logic                 result_ecc_q, result_ecc_d;
    logic [31:0]          jobs_completed_q, jobs_completed_d;

    logic                 bot_in_ready;
    logic                 bot_xfer;

    // Ready decodes come straight from the state register; botInReady
    // also folds in backpressure so a stalled cycle never transfers.
    assign jobReady     = (state_q == S_IDLE);
    assign bot_in_ready = (state_q == S_STREAM) && !slowDownInput &&
                          (remaining_q != 16'd0);
    assign bot_xfer     = botInValid && bot_in_ready;

    always_comb begin
        state_d          = state_q;
        settle_cnt_d     = settle_cnt_q;
        remaining_d      = remaining_q;
        top_d            = top_q;
        bot_d            = bot_q;
        bot_valid_d      = 1'b0;
        result_sum_d     = result_sum_q;
        result_count_d   = result_count_q;
        result_ecc_d     = result_ecc_q;
        jobs_completed_d = jobs_completed_q;

        case (state_q)
            S_IDLE: begin
                if (jobValid) begin
                    top_d        = jobTop;
                    remaining_d  = jobBotCount;
                    settle_cnt_d = '0;
                    state_d      = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = (remaining_q != 16'd0) ? S_STREAM : S_DONE;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            S_STREAM: begin
                if (bot_xfer) begin
                    bot_d       = botIn;
                    bot_valid_d = 1'b1;
                    remaining_d = remaining_q - 16'd1;
                    if (remaining_q == 16'd1) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_WAIT_RES;
            end
            S_WAIT_RES: begin
                if (resultsAvailable) begin
                    result_sum_d   = pcoeffSum;
                    result_count_d = pcoeffCount;
                    result_ecc_d   = eccStatus;
                    state_d        = S_GRAB;
                end
            end
            S_GRAB: begin
                state_d = S_OUTPUT;
            end
            S_OUTPUT: begin
                if (result_valid_q && resultReady) begin
                    jobs_completed_d = jobs_completed_q + 32'd1;
                    state_d          = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Pulse outputs are registered against the next state, so each is
        // high for exactly the cycles spent in its state. batchDone thus
        // rises together with the final botValid and is independent of
        // backpressure.
        batch_done_d   = (state_d == S_DONE);
        grab_results_d = (state_d == S_GRAB);
        result_valid_d = (state_d == S_OUTPUT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= S_IDLE;
            settle_cnt_q     <= '0;
            remaining_q      <= '0;
            top_q            <= '0;
            bot_q            <= '0;
            bot_valid_q      <= 1'b0;
            batch_done_q     <= 1'b0;
            grab_results_q   <= 1'b0;
            result_valid_q   <= 1'b0;
            result_sum_q     <= '0;
            result_count_q   <= '0;
            result_ecc_q     <= 1'b0;
            jobs_completed_q <= '0;
        end else begin
            state_q          <= state_d;
            settle_cnt_q     <= settle_cnt_d;
            remaining_q      <= remaining_d;
            top_q            <= top_d;
            bot_q            <= bot_d;
            bot_valid_q      <= bot_valid_d;
            batch_done_q     <= batch_done_d;
            grab_results_q   <= grab_results_d;
            result_valid_q   <= result_valid_d;
            result_sum_q     <= result_sum_d;
            result_count_q   <= result_count_d;
            result_ecc_q     <= result_ecc_d;
            jobs_completed_q <= jobs_completed_d;
        end
    end

    assign botInReady    = bot_in_ready;
    assign top           = top_q;
    assign bot           = bot_q;
    assign botValid      = bot_valid_q;
    assign batchDone     = batch_done_q;
    assign grabResults   = grab_results_q;
    assign resultValid   = result_valid_q;
    assign resultSum     = result_sum_q;
    assign resultCount   = result_count_q;
    assign resultEcc     = result_ecc_q;
    assign jobsCompleted = jobs_completed_q;

endmodule

// File: tb/tb_permute_job_driver.sv
module tb_permute_job_driver;

    localparam int TS = 4;
    localparam int SW = 52;
    localparam int CW = 17;

    logic           clk = 1'b0;
    logic           rst;
    logic           jobValid, jobReady;
    logic [127:0]   jobTop;
    logic [15:0]    jobBotCount;
    logic [127:0]   botIn;
    logic           botInValid, botInReady;
    logic [127:0]   top, bot;
    logic           botValid, batchDone, slowDownInput;
    logic           resultsAvailable;
    logic [SW-1:0]  pcoeffSum;
    logic [CW-1:0]  pcoeffCount;
    logic           eccStatus, grabResults, resultValid, resultReady;
    logic [SW-1:0]  resultSum;
    logic [CW-1:0]  resultCount;
    logic           resultEcc;
    logic [31:0]    jobsCompleted;

    always #5 clk = ~clk;

    permute_job_driver #(.TOP_SETTLE(TS), .SUM_W(SW), .COUNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .jobValid(jobValid), .jobReady(jobReady),
        .jobTop(jobTop), .jobBotCount(jobBotCount),
        .botIn(botIn), .botInValid(botInValid), .botInReady(botInReady),
        .top(top), .bot(bot), .botValid(botValid), .batchDone(batchDone),
        .slowDownInput(slowDownInput),
        .resultsAvailable(resultsAvailable), .pcoeffSum(pcoeffSum),
        .pcoeffCount(pcoeffCount), .eccStatus(eccStatus),
        .grabResults(grabResults),
        .resultValid(resultValid), .resultReady(resultReady),
        .resultSum(resultSum), .resultCount(resultCount), .resultEcc(resultEcc),
        .jobsCompleted(jobsCompleted)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: job phases as described by the behaviour rules.
    localparam int M_IDLE = 0, M_SETTLE = 1, M_STREAM = 2, M_DONE = 3,
                   M_WAIT = 4, M_GRAB = 5, M_OUT = 6;
    int            m_ph;
    int            m_settle_left;
    int            m_rem;
    logic [127:0]  m_top, m_bot;
    logic          m_bv;
    logic [SW-1:0] m_sum;
    logic [CW-1:0] m_cnt;
    logic          m_ecc;
    logic [31:0]   m_jobs;
    logic [127:0]  sent_q[$];
    int            bv_seen = 0;
    int            bd_seen = 0;

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = M_IDLE; m_settle_left = 0; m_rem = 0;
        m_top = '0; m_bot = '0; m_bv = 1'b0;
        m_sum = '0; m_cnt = '0; m_ecc = 1'b0; m_jobs = '0;
        sent_q.delete();
    endtask

    task automatic check_regs();
        chk("top", top, m_top);
        chk("bot", bot, m_bot);
        chk("botValid", 128'(botValid), 128'(m_bv));
        chk("batchDone", 128'(batchDone), 128'(m_ph == M_DONE));
        chk("grabResults", 128'(grabResults), 128'(m_ph == M_GRAB));
        chk("resultValid", 128'(resultValid), 128'(m_ph == M_OUT));
        chk("resultSum", 128'(resultSum), 128'(m_sum));
        chk("resultCount", 128'(resultCount), 128'(m_cnt));
        chk("resultEcc", 128'(resultEcc), 128'(m_ecc));
        chk("jobsCompleted", 128'(jobsCompleted), 128'(m_jobs));
    endtask

    // Called at posedge+1 with inputs already applied; advances one cycle.
    task automatic tick();
        logic xfer;
        #1;
        chk("jobReady", 128'(jobReady), 128'(m_ph == M_IDLE));
        chk("botInReady", 128'(botInReady),
            128'(m_ph == M_STREAM && !slowDownInput && m_rem != 0));
        xfer = (m_ph == M_STREAM) && !slowDownInput && (m_rem != 0) && botInValid;
        m_bv = xfer;
        case (m_ph)
            M_IDLE: if (jobValid) begin
                m_top = jobTop; m_rem = int'(jobBotCount);
                m_settle_left = TS; m_ph = M_SETTLE;
            end
            M_SETTLE: begin
                m_settle_left--;
                if (m_settle_left <= 0) m_ph = (m_rem == 0) ? M_DONE : M_STREAM;
            end
            M_STREAM: if (xfer) begin
                m_bot = botIn; sent_q.push_back(botIn); m_rem--;
                if (m_rem == 0) m_ph = M_DONE;
            end
            M_DONE: m_ph = M_WAIT;
            M_WAIT: if (resultsAvailable) begin
                m_sum = pcoeffSum; m_cnt = pcoeffCount; m_ecc = eccStatus;
                m_ph = M_GRAB;
            end
            M_GRAB: m_ph = M_OUT;
            M_OUT: if (resultReady) begin
                m_jobs = m_jobs + 32'd1; m_ph = M_IDLE;
            end
            default: m_ph = M_IDLE;
        endcase
        @(posedge clk);
        #1;
        check_regs();
        if (botValid) begin
            bv_seen++;
            if (sent_q.size() == 0) chk("bot_order_extra", 128'(botValid), 128'(0));
            else chk("bot_order", bot, sent_q.pop_front());
        end
        if (batchDone) bd_seen++;
    endtask

    task automatic reset_and_check();
        rst = 1'b1;
        jobValid = 1'b0; botInValid = 1'b0; slowDownInput = 1'b0;
        resultsAvailable = 1'b0; resultReady = 1'b0;
        #1;
        chk("rst_top", top, 128'(0));
        chk("rst_bot", bot, 128'(0));
        chk("rst_botValid", 128'(botValid), 128'(0));
        chk("rst_batchDone", 128'(batchDone), 128'(0));
        chk("rst_grab", 128'(grabResults), 128'(0));
        chk("rst_resultValid", 128'(resultValid), 128'(0));
        chk("rst_botInReady", 128'(botInReady), 128'(0));
        chk("rst_resultSum", 128'(resultSum), 128'(0));
        chk("rst_resultCount", 128'(resultCount), 128'(0));
        chk("rst_resultEcc", 128'(resultEcc), 128'(0));
        chk("rst_jobs", 128'(jobsCompleted), 128'(0));
        model_reset();
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst_hold_batchDone", 128'(batchDone), 128'(0));
            chk("rst_hold_grab", 128'(grabResults), 128'(0));
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check_regs();
        chk("jobReady_after_rst", 128'(jobReady), 128'(1));
    endtask

    // mode bits: 1 = 5-cycle slowdown burst after first bot, 2 = hold
    // resultReady low 10 cycles, 4 = resultsAvailable always high,
    // 8 = bots always valid and no random backpressure, 16 = reset after 2 bots
    task automatic run_job(input int cnt, input logic [SW-1:0] sum,
                           input logic [CW-1:0] rcnt, input int mode);
        int bv0, bd0, budget, slow_left, out_cycles;
        logic [31:0] jobs0;
        bit burst_done, seen_out, aborted;
        bv0 = bv_seen; bd0 = bd_seen; jobs0 = m_jobs;
        budget = 0; slow_left = 0; out_cycles = 0;
        burst_done = 0; seen_out = 0; aborted = 0;
        jobValid = 1'b1; jobTop = rnd128(); jobBotCount = 16'(cnt);
        botInValid = 1'b1; botIn = rnd128(); slowDownInput = 1'b0;
        resultsAvailable = 1'($urandom % 2); resultReady = 1'b1;
        pcoeffSum = sum; pcoeffCount = rcnt; eccStatus = 1'b0;
        tick();
        jobValid = 1'b0;
        while (m_ph != M_IDLE && budget < 2000) begin
            jobTop = rnd128();
            jobBotCount = 16'($urandom);
            botIn = rnd128();
            if ((mode & 8) != 0) begin
                botInValid = 1'b1; slowDownInput = 1'b0;
            end else begin
                botInValid = ($urandom % 4) != 0;
                slowDownInput = ($urandom % 5) == 0;
            end
            if ((mode & 1) != 0 && !burst_done && m_ph == M_STREAM && m_rem == cnt - 1) begin
                slow_left = 5; burst_done = 1;
            end
            if (slow_left > 0) begin
                slowDownInput = 1'b1; slow_left--;
            end
            resultsAvailable = ((mode & 4) != 0) ? 1'b1 : (($urandom % 3) == 0);
            eccStatus = 1'($urandom % 2);
            if (m_ph == M_OUT) out_cycles++;
            resultReady = ((mode & 2) != 0 && out_cycles <= 10) ? 1'b0 : 1'($urandom % 2);
            tick();
            budget++;
            if (m_ph == M_OUT && !seen_out) begin
                seen_out = 1;
                chk("job_resultSum", 128'(resultSum), 128'(sum));
                chk("job_resultCount", 128'(resultCount), 128'(rcnt));
            end
            if ((mode & 2) != 0 && m_ph == M_OUT)
                chk("hold_jobReady", 128'(jobReady), 128'(0));
            if ((mode & 16) != 0 && m_ph == M_STREAM && m_rem == cnt - 2) begin
                aborted = 1;
                break;
            end
        end
        if (aborted) begin
            reset_and_check();
        end else begin
            chk("job_botValid_count", 128'(bv_seen - bv0), 128'(cnt));
            chk("job_batchDone_count", 128'(bd_seen - bd0), 128'(1));
            chk("job_jobsCompleted", 128'(jobsCompleted), 128'(jobs0 + 32'd1));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        jobTop = '0; jobBotCount = '0; botIn = '0;
        pcoeffSum = '0; pcoeffCount = '0; eccStatus = 1'b0;
        model_reset();
        reset_and_check();

        // three bots, no backpressure
        run_job(3, SW'({$urandom, $urandom}), CW'($urandom), 8);
        // four bots with a five-cycle slowdown mid-stream
        run_job(4, SW'({$urandom, $urandom}), CW'($urandom), 9);
        // zero-bot job with sum=5, count=2
        run_job(0, SW'(5), CW'(2), 0);
        // downstream holds resultReady low for ten cycles
        run_job(2, SW'({$urandom, $urandom}), CW'($urandom), 2 | 8);
        // pipeline claims results available throughout streaming
        run_job(3, SW'({$urandom, $urandom}), CW'($urandom), 4);
        // reset after two of five bots, then a normal job
        run_job(5, SW'({$urandom, $urandom}), CW'($urandom), 16 | 8);
        run_job(2, SW'({$urandom, $urandom}), CW'($urandom), 0);

        // randomized jobs
        for (int j = 0; j < 10; j++) begin
            int modes[3] = '{0, 2, 4};
            run_job(int'($urandom_range(0, 6)), SW'({$urandom, $urandom}),
                    CW'($urandom), modes[$urandom_range(0, 2)]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/permute_job_driver.md
PERMUTE_JOB_DRIVER -- requirements
Module: permute_job_driver

Interface
REQ-001 Parameter TOP_SETTLE, default 4: idle cycles between top update and first bot.
REQ-002 Parameter SUM_W, default 52; COUNT_W, default 17: result field widths.
REQ-003 clk  in  1  sole clock; all logic on posedge clk.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 jobValid  in  1  new job offered.
REQ-006 jobReady  out  1  job accepted when jobValid&&jobReady.
REQ-007 jobTop  in  128  top function for the job.
REQ-008 jobBotCount  in  16  number of bots in the job (0 legal).
REQ-009 botIn  in  128  bot source data.
REQ-010 botInValid  in  1  botIn valid.
REQ-011 botInReady  out  1  bot consumed when botInValid&&botInReady.
REQ-012 top  out  128  registered top to pipeline, stable for the whole job.
REQ-013 bot  out  128  registered bot to pipeline.
REQ-014 botValid  out  1  bot output valid, one bot per asserted cycle.
REQ-015 batchDone  out  1  one-cycle end-of-batch pulse.
REQ-016 slowDownInput  in  1  pipeline backpressure.
REQ-017 resultsAvailable  in  1  pipeline has a finished result.
REQ-018 pcoeffSum  in  SUM_W  result sum, valid while resultsAvailable.
REQ-019 pcoeffCount  in  COUNT_W  result count, valid while resultsAvailable.
REQ-020 eccStatus  in  1  pipeline ECC error flag.
REQ-021 grabResults  out  1  one-cycle result acknowledge.
REQ-022 resultValid / resultReady  out / in  1  downstream result handshake.
REQ-023 resultSum / resultCount / resultEcc  out  SUM_W / COUNT_W / 1  captured result.
REQ-024 jobsCompleted  out  32  count of results delivered downstream.

Function
REQ-025 States: IDLE, SETTLE, STREAM, DONE, WAIT_RES, GRAB, OUTPUT; one job in flight.
REQ-026 IDLE: jobReady=1; on accept, latch jobTop into top, jobBotCount into remaining, clear settle counter -> SETTLE.
REQ-027 SETTLE: count TOP_SETTLE cycles -> STREAM if remaining!=0, else DONE.
REQ-028 STREAM: botInReady = !slowDownInput && remaining!=0; each transfer registers botIn into bot, asserts botValid next cycle, decrements remaining.
REQ-029 No transfer -> botValid=0 next cycle; bot holds last value.
REQ-030 slowDownInput=1 -> no transfer that cycle, irrespective of botInValid.
REQ-031 Transfer making remaining 0 -> DONE next cycle; in DONE batchDone=1 exactly one cycle, coinciding with or after the final botValid, never before -> WAIT_RES.
REQ-032 batchDone shall not depend on slowDownInput.
REQ-033 WAIT_RES: on resultsAvailable=1 capture pcoeffSum, pcoeffCount, eccStatus into result regs -> GRAB.
REQ-034 GRAB: grabResults=1 exactly one cycle -> OUTPUT.
REQ-035 OUTPUT: resultValid=1, result regs held stable until resultValid&&resultReady; then jobsCompleted+=1 (wraps at 2^32) -> IDLE.
REQ-036 resultsAvailable outside WAIT_RES ignored; grabResults never asserted outside GRAB.
REQ-037 jobReady=0 in every state except IDLE; botInReady=0 in every state except STREAM.
REQ-038 Zero-bot job: no botValid, batchDone still pulsed, result still collected.

Reset
REQ-039 rst=1 asynchronously forces IDLE; top, bot, result regs, remaining, jobsCompleted = 0; botValid, batchDone, grabResults, resultValid, botInReady = 0; jobReady=1 after release.
REQ-040 Reset mid-job abandons the job with no batchDone, grabResults, or result emitted.

Verification
REQ-041 Job top=T, count=3, bots B0..B2, no backpressure -> botValid 3 consecutive cycles after TOP_SETTLE, batchDone 1 cycle, top==T throughout.
REQ-042 slowDownInput high 5 cycles mid-stream, count=4 -> exactly 4 botValid pulses, none while slowDownInput high (+1 cycle register lag), order preserved.
REQ-043 count=0 -> zero botValid, one batchDone, then resultsAvailable with sum=0x5, count=0x2 -> one grabResults pulse, resultSum=5, resultCount=2.
REQ-044 resultReady held 0 for 10 cycles -> resultValid stays high, values stable, jobReady=0; on ready jobsCompleted increments by 1.
REQ-045 resultsAvailable=1 during STREAM -> no capture, no grabResults until WAIT_RES.
REQ-046 rst asserted during STREAM after 2 of 5 bots -> all outputs 0 same cycle, no batchDone; next job runs normally from IDLE.
